// File: rtl/uart_mmio_bridge_pkg.sv
// Shared types and constants for the UART MMIO bridge.
package uart_bridge_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned LANES    = 8;
  localparam int unsigned WIN_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StCapture,
    StResp
  } state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lane_of(input logic [LANES-1:0] mask);
    logic [2:0] lane;
    lane = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (mask[i]) lane = 3'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// CPU-side valid/ready request/response bus of the UART bridge.
interface uart_mmio_bridge_if;
  import uart_bridge_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [XLEN-1:0]     req_addr;
  logic                req_wen;
  logic [XLEN-1:0]     req_wdata;
  logic [LANES-1:0]    req_wmask;
  logic                resp_valid;
  logic                resp_ready;
  logic [XLEN-1:0]     resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/uart_mmio_bridge_mask_scan.sv
// Lowest-set-bit encoder used to pick the next byte lane to write.
module uart_mask_scan
  import uart_bridge_pkg::*;
(
  input  logic [LANES-1:0] i_mask,
  output logic [2:0]       o_lane,
  output logic             o_any
);

  // Pure decode of the remaining byte-enable mask.
  always_comb begin
    o_lane = lane_of(i_mask);
    o_any  = |i_mask;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Serializes 64-bit MMIO requests into single-byte UART model strobes.
module uart_mmio_bridge
  import uart_bridge_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  uart_mmio_bridge_if.slave   bus,
  output logic                o_uart_wen,
  output logic [7:0]          o_uart_waddr,
  output logic [7:0]          o_uart_wdata,
  output logic                o_uart_ren,
  output logic [7:0]          o_uart_raddr,
  input  logic [XLEN-1:0]     i_uart_rdata
);

  state_e              r_state;
  logic [WIN_BITS-1:0] r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic [LANES-1:0]    r_mask;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [XLEN-1:0]     r_resp_rdata;
  logic                r_uart_wen;
  logic [7:0]          r_uart_waddr;
  logic [7:0]          r_uart_wdata;
  logic                r_uart_ren;
  logic [7:0]          r_uart_raddr;

  logic [LANES-1:0]    w_scan_mask;
  logic [WIN_BITS-1:0] w_addr_src;
  logic [XLEN-1:0]     w_wdata_src;
  logic [2:0]          w_lane;
  logic                w_any;
  logic [LANES-1:0]    w_mask_rest;
  logic [7:0]          w_waddr;
  logic [7:0]          w_wbyte;
  logic                w_unused;

  // Only the register window and the low read byte matter.
  assign w_unused = ^{bus.req_addr[XLEN-1:WIN_BITS], i_uart_rdata[XLEN-1:8]};

  // In IDLE the first lane is taken straight from the request so the first
  // strobe lands in the cycle after acceptance; afterwards from the latched copy.
  always_comb begin
    w_scan_mask = r_mask;
    w_addr_src  = r_addr;
    w_wdata_src = r_wdata;
    if (r_state == StIdle) begin
      w_scan_mask = bus.req_wmask;
      w_addr_src  = bus.req_addr[WIN_BITS-1:0];
      w_wdata_src = bus.req_wdata;
    end
  end

  uart_mask_scan u_mask_scan (
    .i_mask (w_scan_mask),
    .o_lane (w_lane),
    .o_any  (w_any)
  );

  // Next byte write derived from the selected lane.
  always_comb begin
    w_mask_rest = w_scan_mask & ~(8'b1 << w_lane);
    w_waddr     = {w_addr_src[7:3], w_lane};
    w_wbyte     = w_wdata_src[{w_lane, 3'b000} +: 8];
  end

  // Bridge FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_uart_wen   <= 1'b0;
      r_uart_waddr <= '0;
      r_uart_wdata <= '0;
      r_uart_ren   <= 1'b0;
      r_uart_raddr <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr[WIN_BITS-1:0];
            r_wdata     <= bus.req_wdata;
            r_req_ready <= 1'b0;
            if (bus.req_wen) begin
              if (w_any) begin
                r_state      <= StWrite;
                r_uart_wen   <= 1'b1;
                r_uart_waddr <= w_waddr;
                r_uart_wdata <= w_wbyte;
                r_mask       <= w_mask_rest;
              end else begin
                r_state      <= StResp;
                r_resp_valid <= 1'b1;
                r_resp_rdata <= '0;
              end
            end else begin
              r_state      <= StRead;
              r_uart_ren   <= 1'b1;
              r_uart_raddr <= bus.req_addr[7:0];
            end
          end
        end
        StWrite: begin
          if (w_any) begin
            r_uart_wen   <= 1'b1;
            r_uart_waddr <= w_waddr;
            r_uart_wdata <= w_wbyte;
            r_mask       <= w_mask_rest;
          end else begin
            r_state      <= StResp;
            r_uart_wen   <= 1'b0;
            r_uart_waddr <= '0;
            r_uart_wdata <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
          end
        end
        StRead: begin
          r_state      <= StCapture;
          r_uart_ren   <= 1'b0;
          r_uart_raddr <= '0;
        end
        StCapture: begin
          r_state      <= StResp;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= XLEN'(i_uart_rdata[7:0]) << {r_addr[2:0], 3'b000};
        end
        StResp: begin
          if (bus.resp_ready) begin
            r_state      <= StIdle;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign o_uart_wen     = r_uart_wen;
  assign o_uart_waddr   = r_uart_waddr;
  assign o_uart_wdata   = r_uart_wdata;
  assign o_uart_ren     = r_uart_ren;
  assign o_uart_raddr   = r_uart_raddr;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Randomized self-checking bench for uart_mmio_bridge against a transaction-level model.
module tb_uart_mmio_bridge;

  logic        clk;
  logic        reset;
  logic        uart_wen;
  logic [7:0]  uart_waddr;
  logic [7:0]  uart_wdata;
  logic        uart_ren;
  logic [7:0]  uart_raddr;
  logic [63:0] uart_rdata;
  logic [7:0]  model_byte;

  int n_checks;
  int n_errors;

  uart_mmio_bridge_if bus ();

  uart_mmio_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_uart_wen   (uart_wen),
    .o_uart_waddr (uart_waddr),
    .o_uart_wdata (uart_wdata),
    .o_uart_ren   (uart_ren),
    .o_uart_raddr (uart_raddr),
    .i_uart_rdata (uart_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: read data appears the cycle after the read strobe edge, with noisy upper bits.
  always @(posedge clk) begin
    if (uart_ren) uart_rdata <= {32'($urandom), 24'($urandom), model_byte};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wen"},   {63'd0, uart_wen}, 64'd0);
    check_eq({tag, "_wbus"},  {48'd0, uart_waddr, uart_wdata}, 64'd0);
    check_eq({tag, "_ren"},   {55'd0, uart_ren, uart_raddr}, 64'd0);
    check_eq({tag, "_rv"},    {63'd0, bus.resp_valid}, 64'd0);
    check_eq({tag, "_rdata"}, bus.resp_rdata, 64'd0);
    check_eq({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  // One request/response; expectations come from the byte-lane rules, not the FSM.
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, input logic [7:0] rbyte, input int stall);
    logic [15:0] exp_q[$];
    logic [15:0] e;
    logic [63:0] exp_rd;
    int          lat;
    int          off;
    int          nren;
    bit          got_resp;

    exp_q.delete();
    off = int'(addr[2:0]);
    if (wen) begin
      for (int l = 0; l < 8; l++) begin
        if (wmask[l]) exp_q.push_back({addr[7:3], l[2:0], wdata[8*l +: 8]});
      end
      lat    = (exp_q.size() == 0) ? 1 : exp_q.size() + 1;
      exp_rd = 64'd0;
    end else begin
      lat    = 3;
      exp_rd = 64'(rbyte) << (8 * off);
    end
    model_byte = rbyte;
    nren       = 0;
    got_resp   = 1'b0;

    @(negedge clk);
    check_eq("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_wmask  = wmask;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    // Scramble the request fields to prove they were latched.
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'($urandom);
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
    bus.req_wmask = 8'($urandom);

    for (int c = 1; c <= 20 && !got_resp; c++) begin
      check_eq("strobe_excl", {63'd0, uart_wen & uart_ren}, 64'd0);
      if (uart_wen) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_wen", {63'd0, uart_wen}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("uart_write", {48'd0, uart_waddr, uart_wdata}, {48'd0, e});
        end
      end else begin
        check_eq("wbus_quiet", {48'd0, uart_waddr, uart_wdata}, 64'd0);
      end
      if (uart_ren) begin
        nren++;
        check_eq("ren_cycle", 64'(c), 64'd1);
        check_eq("raddr", {56'd0, uart_raddr}, {56'd0, addr[7:0]});
      end else begin
        check_eq("raddr_quiet", {56'd0, uart_raddr}, 64'd0);
      end
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        check_eq("resp_latency", 64'(c), 64'(lat));
      end else begin
        check_eq("busy_ready", {63'd0, bus.req_ready}, 64'd0);
        @(negedge clk);
      end
    end
    if (!got_resp) check_eq("resp_timeout", {63'd0, bus.resp_valid}, 64'd1);
    check_eq("writes_left", 64'(exp_q.size()), 64'd0);
    check_eq("ren_count", 64'(nren), wen ? 64'd0 : 64'd1);
    check_eq("resp_rdata", bus.resp_rdata, exp_rd);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("hold_valid", {63'd0, bus.resp_valid}, 64'd1);
      check_eq("hold_rdata", bus.resp_rdata, exp_rd);
      check_eq("hold_ready", {63'd0, bus.req_ready}, 64'd0);
      check_eq("hold_strobes", {62'd0, uart_wen, uart_ren}, 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_eq("post_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("post_ready", {63'd0, bus.req_ready}, 64'd1);
  endtask

  // Reset in the middle of an 8-lane write, right after the third byte strobe.
  task automatic reset_mid_write();
    int nwen;
    nwen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 64'h18;
    bus.req_wdata = {$urandom, $urandom};
    bus.req_wmask = 8'hFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 12 && nwen < 3; c++) begin
      if (uart_wen) nwen++;
      if (nwen < 3) @(negedge clk);
    end
    check_eq("rst_three_writes", 64'(nwen), 64'd3);
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("rst_hold_wen", {63'd0, uart_wen}, 64'd0);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("rst_after_wen", {63'd0, uart_wen}, 64'd0);
      check_eq("rst_after_rv", {63'd0, bus.resp_valid}, 64'd0);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    model_byte     = 8'd0;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    bus.req_wmask  = 8'd0;
    bus.resp_ready = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("out_of_reset");

    do_req(1'b0, 64'h05, 64'd0, 8'h00, 8'h41, 0);
    do_req(1'b1, 64'h00, 64'h48, 8'h01, 8'h00, 0);
    do_req(1'b1, 64'h00, 64'hAA00_0000_0000_BB00, 8'h82, 8'h00, 0);
    do_req(1'b1, 64'h10, 64'h1234_5678_9ABC_DEF0, 8'h00, 8'h00, 0);
    do_req(1'b0, 64'h2F, 64'd0, 8'h00, 8'hC3, 5);
    do_req(1'b1, 64'hFFFF_0000_0000_00F8, 64'h0102_0304_0506_0708, 8'hFF, 8'h00, 2);

    reset_mid_write();
    do_req(1'b0, 64'h03, 64'd0, 8'h00, 8'h5A, 1);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] m;
      m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      do_req(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, m, 8'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
